// File: rtl/spi_sram_responder.sv
// SPI mode-3 slave emulating a serial SRAM: 40-bit frames {cmd, addr, data_lo, data_hi},
// with 0x02 = burst write and 0x03 = burst read of a 16-bit word memory. All logic runs on clk.
module spi_sram_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic clk,
  input  logic resetb,
  input  logic sclk_i,
  input  logic csb_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic busy_o,
  output logic wr_pulse_o,
  output logic cmd_err_o
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

  state_t              state;
  logic [2:0]          sclk_sync;
  logic [1:0]          csb_sync;
  logic [1:0]          mosi_sync;
  logic                csb_d;
  logic [4:0]          bit_cnt;
  logic [15:0]         shift;
  logic                is_read;
  logic [ADDR_W-1:0]   addr;
  logic [15:0]         tx;
  logic [15:0]         mem [2**ADDR_W];

  logic                sclk_rise, sclk_fall, csb_rise, csb_fall;
  logic [15:0]         shift_nxt;
  logic [15:0]         wdata;
  logic [ADDR_W-1:0]   addr_inc;
  logic                wr_commit;
  logic [3:0]          tx_idx;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync <= '1;
      csb_sync  <= '1;
      csb_d     <= 1'b1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_i};
      csb_sync  <= {csb_sync[0], csb_i};
      csb_d     <= csb_sync[1];
      mosi_sync <= {mosi_sync[0], mosi_i};
    end
  end

  always_comb begin
    sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    csb_rise  = csb_sync[1] & ~csb_d;
    csb_fall  = ~csb_sync[1] & csb_d;
    shift_nxt = {shift[14:0], mosi_sync[1]};
    // first received byte is the low data byte
    wdata     = {shift_nxt[7:0], shift_nxt[15:8]};
    addr_inc  = addr + ADDR_W'(1);
    // commit is tied to the 16th data edge even if CSB rises in the same clk
    wr_commit = (state == WDATA) && sclk_rise && (bit_cnt == 5'd15);
    // bits 0..7 send tx[7:0] MSB first, bits 8..15 send tx[15:8] MSB first
    tx_idx    = {bit_cnt[3], ~bit_cnt[2:0]};
  end

  always_ff @(posedge clk) begin
    if (wr_commit)
      mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      is_read    <= 1'b0;
      addr       <= '0;
      tx         <= '0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      busy_o     <= 1'b0;
      wr_pulse_o <= 1'b0;
      cmd_err_o  <= 1'b0;
    end else begin
      busy_o     <= ~csb_sync[1];
      wr_pulse_o <= wr_commit;
      cmd_err_o  <= 1'b0;
      if (csb_rise) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        miso_oe_o <= 1'b0;
      end else if (csb_fall) begin
        state     <= CMD;
        bit_cnt   <= '0;
        miso_oe_o <= 1'b0;
      end else begin
        unique case (state)
          CMD: if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              if (shift_nxt[7:0] == 8'h02) begin
                is_read <= 1'b0;
                state   <= ADDR;
              end else if (shift_nxt[7:0] == 8'h03) begin
                is_read <= 1'b1;
                state   <= ADDR;
              end else begin
                cmd_err_o <= 1'b1;
                state     <= IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          ADDR: if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              addr    <= shift_nxt[ADDR_W-1:0];
              if (is_read) begin
                tx    <= mem[shift_nxt[ADDR_W-1:0]];
                state <= RDATA;
              end else begin
                state <= WDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          WDATA: if (sclk_rise) begin
            shift <= shift_nxt;
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          RDATA: if (sclk_fall) begin
            miso_o    <= tx[tx_idx];
            miso_oe_o <= 1'b1;
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              tx      <= mem[addr_inc];
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Scoreboard bench for spi_sram_responder: an SPI master task drives frames, a word-level
// memory model queues expected reads/writes/errors, and monitor processes check DUT outputs.
module tb_spi_sram_responder;

  localparam int unsigned AW   = 10;
  localparam int unsigned HALF = 8;

  logic clk = 1'b0;
  logic resetb, sclk_i, csb_i, mosi_i;
  logic miso_o, miso_oe_o, busy_o, wr_pulse_o, cmd_err_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [1024];
  logic [15:0] exp_rd [$];
  logic [15:0] exp_wr [$];
  int          exp_err [$];
  bit          rd_phase   = 1'b0;
  bit          oe_allowed = 1'b0;
  bit          oe_viol    = 1'b0;

  spi_sram_responder #(.ADDR_W(AW)) dut (
    .clk(clk), .resetb(resetb), .sclk_i(sclk_i), .csb_i(csb_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .busy_o(busy_o),
    .wr_pulse_o(wr_pulse_o), .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // read monitor: master samples MISO on SCLK rise
  logic [15:0] rsh;
  int          rnb = 0;
  always @(posedge sclk_i) begin
    if (rd_phase) begin
      total++;
      if (miso_oe_o !== 1'b1) begin
        bad++;
        $display("FAIL rd_oe: got %b expected 1", miso_oe_o);
      end
      rsh = {rsh[14:0], miso_o};
      rnb++;
      if (rnb == 16) begin
        rnb = 0;
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got %h expected none", {rsh[7:0], rsh[15:8]});
        end else begin
          logic [15:0] e;
          e = exp_rd.pop_front();
          if ({rsh[7:0], rsh[15:8]} !== e) begin
            bad++;
            $display("FAIL rd_data: got %h expected %h", {rsh[7:0], rsh[15:8]}, e);
          end
        end
      end
    end else begin
      rnb = 0;
    end
  end

  always @(negedge clk) begin
    if (wr_pulse_o === 1'b1) begin
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL wr_pulse: got unexpected pulse expected none");
      end else begin
        void'(exp_wr.pop_front());
      end
    end
    if (cmd_err_o === 1'b1) begin
      total++;
      if (exp_err.size() == 0) begin
        bad++;
        $display("FAIL cmd_err: got unexpected pulse expected none");
      end else begin
        void'(exp_err.pop_front());
      end
    end
    if (miso_oe_o === 1'b1 && !oe_allowed) oe_viol = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_cycle(input logic b);
    sclk_i = 1'b0;
    mosi_i = b;
    wait_clk(HALF);
    sclk_i = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle(v[i]);
  endtask

  task automatic csb_low();
    csb_i = 1'b0;
    wait_clk(8);
  endtask

  task automatic csb_high();
    wait_clk(8);
    csb_i = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_frame(input logic [15:0] a16, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2, input int n);
    logic [15:0] w;
    csb_low();
    check("busy", {15'd0, busy_o}, 16'd1);
    send_bits(16'h0002, 8);
    send_bits(a16, 16);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      mdl[(a16 % 1024 + k) % 1024] = w;
      exp_wr.push_back(w);
      send_bits({8'h00, w[7:0]}, 8);
      send_bits({8'h00, w[15:8]}, 8);
    end
    csb_high();
  endtask

  task automatic read_frame(input logic [15:0] a16, input int n);
    for (int k = 0; k < n; k++) exp_rd.push_back(mdl[(a16 % 1024 + k) % 1024]);
    csb_low();
    send_bits(16'h0003, 8);
    send_bits(a16, 16);
    oe_allowed = 1'b1;
    rd_phase   = 1'b1;
    for (int k = 0; k < 16 * n; k++) sclk_cycle(1'b0);
    rd_phase = 1'b0;
    csb_high();
    check("oe_after_csb", {15'd0, miso_oe_o}, 16'd0);
    oe_allowed = 1'b0;
  endtask

  initial begin
    resetb = 1'b0; csb_i = 1'b1; sclk_i = 1'b1; mosi_i = 1'b0;
    wait_clk(4);
    check("rst_miso",  {15'd0, miso_o},     16'd0);
    check("rst_oe",    {15'd0, miso_oe_o},  16'd0);
    check("rst_busy",  {15'd0, busy_o},     16'd0);
    check("rst_wr",    {15'd0, wr_pulse_o}, 16'd0);
    check("rst_err",   {15'd0, cmd_err_o},  16'd0);
    resetb = 1'b1;
    wait_clk(6);

    write_frame(16'h0005, 16'h1234, 16'h0, 16'h0, 1);
    read_frame(16'h0005, 1);

    exp_err.push_back(1);
    csb_low();
    send_bits(16'h00A5, 8);
    send_bits(16'($urandom), 16);
    send_bits(16'($urandom), 16);
    csb_high();

    write_frame(16'h03FF, 16'hBEEF, 16'hCAFE, 16'h0, 2);
    read_frame(16'h03FF, 2);

    csb_low();
    send_bits(16'h0002, 8);
    send_bits(16'h0405, 16);
    send_bits(16'h00AB, 8);
    csb_high();
    read_frame(16'h0005, 1);

    for (int it = 0; it < 6; it++) begin
      logic [15:0] a;
      int n;
      a = 16'($urandom);
      n = int'($urandom_range(1, 3));
      write_frame(a, 16'($urandom), 16'($urandom), 16'($urandom), n);
      read_frame(a, n);
    end

    // reset in the middle of a read, then recover
    csb_low();
    send_bits(16'h0003, 8);
    send_bits(16'h0005, 16);
    oe_allowed = 1'b1;
    send_bits(16'h0000, 5);
    resetb = 1'b0;
    #1;
    check("midrst_oe",   {15'd0, miso_oe_o}, 16'd0);
    check("midrst_busy", {15'd0, busy_o},    16'd0);
    check("midrst_miso", {15'd0, miso_o},    16'd0);
    wait_clk(4);
    csb_i = 1'b1;
    wait_clk(4);
    resetb = 1'b1;
    wait_clk(6);
    oe_allowed = 1'b0;
    read_frame(16'h0005, 1);
    read_frame(16'h03FF, 2);

    wait_clk(20);
    check("oe_outside_read", {15'd0, oe_viol}, 16'd0);
    check("rd_pending",  16'(exp_rd.size()),  16'd0);
    check("wr_pending",  16'(exp_wr.size()),  16'd0);
    check("err_pending", 16'(exp_err.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
